// File: rtl/rock_controller.sv
// Rocking-motor sequencer: owns the frequency/amplitude settings, applies adjust
// commands on a prescaled tick and drives the direction square wave.
// Optional: define ROCK_CMD_COUNT_EN to add the cmd_count output.
module rock_controller #(
  parameter int TICK_DIV   = 50000,
  parameter int FREQ_W     = 4,
  parameter int AMP_W      = 4,
  parameter int FREQ_INIT  = 8,
  parameter int AMP_INIT   = 8,
  parameter int HOLD_TICKS = 8,
  parameter int CALM_TICKS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              fmin,
  input  logic              fplus,
  input  logic              amin,
  input  logic              aplus,
  output logic [FREQ_W-1:0] freq_set,
  output logic [AMP_W-1:0]  amp_set,
  output logic              motor_dir,
  output logic              motor_en,
  output logic              tick,
  output logic              chg_evt,
  output logic [1:0]        state
`ifdef ROCK_CMD_COUNT_EN
  ,
  output logic [7:0]        cmd_count
`endif
);

  localparam int TW  = $clog2(TICK_DIV);
  localparam int HW  = $clog2(HOLD_TICKS + 1);
  localparam int CW  = $clog2(CALM_TICKS + 1);
  localparam int HPW = FREQ_W + 2;

  localparam logic [TW-1:0]     TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0]     CALM_LAST = CW'(CALM_TICKS - 1);
  localparam logic [FREQ_W-1:0] FREQ_MAX  = '1;
  localparam logic [AMP_W-1:0]  AMP_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     div_q, div_d;
  logic [FREQ_W-1:0] freq_q, freq_d, freq_next;
  logic [AMP_W-1:0]  amp_q, amp_d, amp_next;
  logic [HW-1:0]     hold_q, hold_d;
  logic [CW-1:0]     calm_q, calm_d;
  logic [HPW-1:0]    hp_q, hp_d, hp_half, hp_reload;
  logic              dir_q, dir_d;
  logic              en_q, en_d;
  logic              chg_q, chg_d;
  logic              tick_w, any_cmd, cmd_chg;
`ifdef ROCK_CMD_COUNT_EN
  logic [7:0]        cnt_q, cnt_d;
  logic              cmd_inc;
`endif

  always_comb begin
    tick_w  = (div_q == TICK_LAST);
    div_d   = tick_w ? '0 : div_q + TW'(1);
    any_cmd = fmin | fplus | amin | aplus;

    freq_next = freq_q;
    if (fplus && !fmin && freq_q != FREQ_MAX) freq_next = freq_q + FREQ_W'(1);
    else if (fmin && !fplus && freq_q != '0)  freq_next = freq_q - FREQ_W'(1);

    amp_next = amp_q;
    if (aplus && !amin && amp_q != AMP_MAX) amp_next = amp_q + AMP_W'(1);
    else if (amin && !aplus && amp_q != '0) amp_next = amp_q - AMP_W'(1);

    cmd_chg = (freq_next != freq_q) || (amp_next != amp_q);

    // Half-period in ticks is 2*(2^FREQ_W - freq); the counter runs down to 0.
    hp_half   = HPW'(2 ** FREQ_W) - {2'b00, freq_q};
    hp_reload = {hp_half[HPW-2:0], 1'b0} - HPW'(1);

    state_d = state_q;
    freq_d  = freq_q;
    amp_d   = amp_q;
    hold_d  = hold_q;
    calm_d  = calm_q;
    hp_d    = hp_q;
    dir_d   = dir_q;
    chg_d   = 1'b0;
`ifdef ROCK_CMD_COUNT_EN
    cmd_inc = 1'b0;
`endif

    if (!enable) begin
      state_d = IDLE;
      hp_d    = '0;
      hold_d  = '0;
      calm_d  = '0;
    end else if (tick_w) begin
      case (state_q)
        IDLE: begin
          state_d = RUN;
          hp_d    = hp_reload;
        end
        RUN: begin
          if (cmd_chg) begin
            freq_d  = freq_next;
            amp_d   = amp_next;
            chg_d   = 1'b1;
            hold_d  = HW'(HOLD_TICKS);
            calm_d  = '0;
            state_d = HOLD;
`ifdef ROCK_CMD_COUNT_EN
            cmd_inc = 1'b1;
`endif
          end else if (any_cmd) begin
            calm_d = '0;
          end else if (calm_q == CALM_LAST) begin
            calm_d = '0;
            if (amp_q != '0) begin
              amp_d = amp_q - AMP_W'(1);
              chg_d = 1'b1;
            end
          end else begin
            calm_d = calm_q + CW'(1);
          end
        end
        HOLD: begin
          hold_d = hold_q - HW'(1);
          if (hold_q <= HW'(1)) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase

      // Reload samples the pre-update frequency, so a change lands at the next reversal.
      if (state_q != IDLE) begin
        if (hp_q == '0) begin
          dir_d = ~dir_q;
          hp_d  = hp_reload;
        end else begin
          hp_d = hp_q - HPW'(1);
        end
      end
    end

    en_d = (state_d != IDLE) && (amp_d != '0);

`ifdef ROCK_CMD_COUNT_EN
    cnt_d = cmd_inc ? cnt_q + 8'd1 : cnt_q;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      freq_q  <= FREQ_W'(FREQ_INIT);
      amp_q   <= AMP_W'(AMP_INIT);
      hold_q  <= '0;
      calm_q  <= '0;
      hp_q    <= '0;
      dir_q   <= 1'b0;
      en_q    <= 1'b0;
      chg_q   <= 1'b0;
`ifdef ROCK_CMD_COUNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      freq_q  <= freq_d;
      amp_q   <= amp_d;
      hold_q  <= hold_d;
      calm_q  <= calm_d;
      hp_q    <= hp_d;
      dir_q   <= dir_d;
      en_q    <= en_d;
      chg_q   <= chg_d;
`ifdef ROCK_CMD_COUNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign freq_set  = freq_q;
  assign amp_set   = amp_q;
  assign motor_dir = dir_q;
  assign motor_en  = en_q;
  assign tick      = tick_w;
  assign chg_evt   = chg_q;
  assign state     = state_q;
`ifdef ROCK_CMD_COUNT_EN
  assign cmd_count = cnt_q;
`endif

endmodule

// File: tb/tb_rock_controller.sv
// Directed, table-driven bench for rock_controller with a small tick prescaler.
module tb_rock_controller;

  localparam int TD = 4;
  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_HOLD = 2;

  logic       clk, reset, enable, fmin, fplus, amin, aplus;
  logic [3:0] freq_set, amp_set;
  logic       motor_dir, motor_en, tick, chg_evt;
  logic [1:0] state;
`ifdef ROCK_CMD_COUNT_EN
  logic [7:0] cmd_count;
`endif

  int checks   = 0;
  int failures = 0;

  rock_controller #(
    .TICK_DIV(TD), .FREQ_W(4), .AMP_W(4), .FREQ_INIT(8), .AMP_INIT(8),
    .HOLD_TICKS(2), .CALM_TICKS(3)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .fmin(fmin), .fplus(fplus), .amin(amin), .aplus(aplus),
    .freq_set(freq_set), .amp_set(amp_set), .motor_dir(motor_dir),
    .motor_en(motor_en), .tick(tick), .chg_evt(chg_evt), .state(state)
`ifdef ROCK_CMD_COUNT_EN
    , .cmd_count(cmd_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int fmin, fplus, amin, aplus;
    int nticks;
    int ef, ea, es, een, echg;
    int cdir, edir;
  } vec_t;

  vec_t tbl [21];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int f_m, input int f_p, input int a_m, input int a_p);
    fmin  = (f_m != 0);
    fplus = (f_p != 0);
    amin  = (a_m != 0);
    aplus = (a_p != 0);
  endtask

  // Moves to just after the next clk edge on which tick is high.
  task automatic advanceTick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * TD; i++) begin
      @(negedge clk);
      if (tick) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic advanceTicks(input int n);
    bit ok;
    for (int i = 0; i < n; i++) begin
      advanceTick(ok);
      if (!ok) begin
        checkOutput("tick_timeout", 0, 1);
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    int n;
    logic prev;

    tbl[0]  = '{0,0,0,0, 2,  8, 7, S_RUN,  1, 1, 1, 0};
    tbl[1]  = '{0,1,0,0, 1,  9, 7, S_HOLD, 1, 1, 1, 0};
    tbl[2]  = '{0,1,0,0, 1,  9, 7, S_HOLD, 1, 0, 0, 0};
    tbl[3]  = '{0,1,0,0, 1,  9, 7, S_RUN,  1, 0, 0, 0};
    tbl[4]  = '{0,1,0,0, 1, 10, 7, S_HOLD, 1, 1, 0, 0};
    tbl[5]  = '{0,0,0,0, 2, 10, 7, S_RUN,  1, 0, 0, 0};
    tbl[6]  = '{1,1,0,1, 1, 10, 8, S_HOLD, 1, 1, 0, 0};
    tbl[7]  = '{0,0,0,0, 2, 10, 8, S_RUN,  1, 0, 0, 0};
    tbl[8]  = '{1,1,0,0, 1, 10, 8, S_RUN,  1, 0, 1, 0};
    tbl[9]  = '{0,0,0,0, 3, 10, 7, S_RUN,  1, 1, 1, 1};
    tbl[10] = '{0,1,0,0, 12, 14, 7, S_RUN, 1, 0, 1, 0};
    tbl[11] = '{0,1,0,0, 1, 15, 7, S_HOLD, 1, 1, 1, 0};
    tbl[12] = '{0,1,0,0, 2, 15, 7, S_RUN,  1, 0, 1, 0};
    tbl[13] = '{0,1,0,0, 1, 15, 7, S_RUN,  1, 0, 1, 1};
    tbl[14] = '{0,1,0,0, 1, 15, 7, S_RUN,  1, 0, 1, 1};
    tbl[15] = '{0,0,0,0, 1, 15, 7, S_RUN,  1, 0, 1, 0};
    tbl[16] = '{1,0,0,0, 45, 0, 7, S_RUN,  1, 0, 0, 0};
    tbl[17] = '{0,0,1,0, 18, 0, 1, S_RUN,  1, 0, 0, 0};
    tbl[18] = '{0,0,1,0, 1,  0, 0, S_HOLD, 0, 1, 0, 0};
    tbl[19] = '{0,0,1,0, 2,  0, 0, S_RUN,  0, 0, 0, 0};
    tbl[20] = '{0,0,1,0, 1,  0, 0, S_RUN,  0, 0, 0, 0};

    reset  = 1'b0;
    enable = 1'b0;
    applyStimulus(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_freq", freq_set, 8);
    checkOutput("rst_amp", amp_set, 8);
    checkOutput("rst_dir", motor_dir, 0);
    checkOutput("rst_en", motor_en, 0);
    checkOutput("rst_tick", tick, 0);
    checkOutput("rst_chg", chg_evt, 0);
    checkOutput("rst_state", state, S_IDLE);

    // First tick lands on the TD-th cycle after release, then every TD cycles.
    @(negedge clk);
    reset  = 1'b1;
    enable = 1'b1;
    n = 0;
    for (int i = 0; i < 3 * TD; i++) begin
      @(negedge clk);
      n++;
      if (tick) break;
    end
    checkOutput("first_tick_delay", n, TD - 1);
    checkOutput("idle_before_tick", state, S_IDLE);
    @(posedge clk);
    #1;
    checkOutput("enter_run_state", state, S_RUN);
    checkOutput("enter_run_en", motor_en, 1);
    checkOutput("enter_run_chg", chg_evt, 0);
    n = 0;
    for (int i = 0; i < 3 * TD; i++) begin
      @(negedge clk);
      n++;
      if (tick) break;
    end
    checkOutput("tick_period", n, TD);
    @(posedge clk);
    #1;

    for (int i = 0; i < 21; i++) begin
      applyStimulus(tbl[i].fmin, tbl[i].fplus, tbl[i].amin, tbl[i].aplus);
      advanceTicks(tbl[i].nticks);
      checkOutput($sformatf("v%0d_freq", i), freq_set, tbl[i].ef);
      checkOutput($sformatf("v%0d_amp", i), amp_set, tbl[i].ea);
      checkOutput($sformatf("v%0d_state", i), state, tbl[i].es);
      checkOutput($sformatf("v%0d_en", i), motor_en, tbl[i].een);
      checkOutput($sformatf("v%0d_chg", i), chg_evt, tbl[i].echg);
      if (tbl[i].cdir != 0)
        checkOutput($sformatf("v%0d_dir", i), motor_dir, tbl[i].edir);
      if (tbl[i].echg != 0) begin
        @(posedge clk);
        #1;
        checkOutput($sformatf("v%0d_chg_clear", i), chg_evt, 0);
      end
    end

    // With freq_set=0 each half-period is 32 ticks.
    applyStimulus(0, 0, 0, 0);
    prev = motor_dir;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      advanceTicks(1);
      if (motor_dir !== prev) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("dir_toggle_seen", ok, 1);
    prev = motor_dir;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      advanceTicks(1);
      n++;
      if (motor_dir !== prev) break;
    end
    checkOutput("half_period_f0", n, 32);

    applyStimulus(0, 0, 0, 1);
    advanceTicks(1);
    checkOutput("aplus_amp", amp_set, 1);
    checkOutput("aplus_state", state, S_HOLD);
    checkOutput("aplus_en", motor_en, 1);
    applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1;
    enable = 1'b1;
    checkOutput("disable_state", state, S_IDLE);
    checkOutput("disable_en", motor_en, 0);
    advanceTicks(1);
    checkOutput("reenable_state", state, S_RUN);
    checkOutput("reenable_freq", freq_set, 0);
    checkOutput("reenable_amp", amp_set, 1);
    checkOutput("reenable_en", motor_en, 1);

    // Asynchronous reset: checked between clock edges.
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("async_rst_freq", freq_set, 8);
    checkOutput("async_rst_amp", amp_set, 8);
    checkOutput("async_rst_dir", motor_dir, 0);
    checkOutput("async_rst_en", motor_en, 0);
    checkOutput("async_rst_state", state, S_IDLE);
    checkOutput("async_rst_chg", chg_evt, 0);
    checkOutput("async_rst_tick", tick, 0);
`ifdef ROCK_CMD_COUNT_EN
    checkOutput("async_rst_cmdcnt", cmd_count, 0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

`ifdef ROCK_CMD_COUNT_EN
    advanceTicks(1);
    for (int k = 0; k < 256; k++) begin
      if (k % 2 == 0) applyStimulus(0, 1, 0, 0);
      else            applyStimulus(1, 0, 0, 0);
      ok = 1'b0;
      for (int j = 0; j < 6; j++) begin
        advanceTicks(1);
        if (chg_evt) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) begin
        checkOutput($sformatf("cmdcnt_chg_timeout_%0d", k), 0, 1);
        break;
      end
      if (k == 0) checkOutput("cmdcnt_first", cmd_count, 1);
    end
    checkOutput("cmdcnt_wrap", cmd_count, 0);
    applyStimulus(0, 0, 0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
